// File: rtl/pcw_pkg.sv
// pcw_pkg -- shared definitions for the PCW palette path.
//   PAL_BYTES            : size of a .gbp fake-colour palette file in bytes
//   PCW_DEFAULT_PALETTE  : palette in effect after reset
//   pal_state_t          : palette loader FSM states
// Optional feature macro: PCW_PAL_VBLANK_SYNC_EN (adds the WAIT_VBL state).
package pcw_pkg;

  localparam int PAL_BYTES = 16;

  localparam logic [127:0] PCW_DEFAULT_PALETTE = 128'h00000032cd320000ff00ffff00000000;

  typedef enum logic [2:0] {
    PAL_IDLE   = 3'd0,
    PAL_RECV   = 3'd1,
    PAL_CHECK  = 3'd2,
    PAL_COMMIT = 3'd3
`ifdef PCW_PAL_VBLANK_SYNC_EN
    , PAL_WAIT_VBL = 3'd4
`endif
  } pal_state_t;

endpackage

// File: rtl/edge_det.sv
// edge_det -- registers a level and reports its rising/falling transitions.
//   clk  : clock
//   rst  : asynchronous active-high reset (history cleared to 0)
//   d    : level to watch
//   rise : d high now, low last cycle (combinational from d and history)
//   fall : d low now, high last cycle
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/pcw_palette_loader.sv
// pcw_palette_loader -- receives a 16-byte .gbp palette over the HPS ioctl
// download channel, stages it in a shadow buffer and commits it to the live
// palette only when every byte arrived and nothing past the end was written.
//   clk_sys, reset       : system clock, asynchronous active-high reset
//   ioctl_download/index : download active / target index (PAL_INDEX selects us)
//   ioctl_wr/addr/data   : one-cycle byte strobe, byte offset, byte value
//   ioctl_wait           : held while checking / waiting for vblank / committing
//   vblank               : core vertical blank (only with PCW_PAL_VBLANK_SYNC_EN)
//   palette              : live palette, byte 0 of the file is the MSB
//   commit_stb           : one-cycle pulse when palette updates
//   load_error           : sticky, the last palette download was rejected
// Macro PCW_PAL_VBLANK_SYNC_EN: defer the commit to the next rising vblank edge.
module pcw_palette_loader
  import pcw_pkg::*;
#(
  parameter logic [7:0]   PAL_INDEX       = 8'd3,
  parameter logic [127:0] DEFAULT_PALETTE = PCW_DEFAULT_PALETTE
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [15:0]  ioctl_addr,
  input  logic [7:0]   ioctl_data,
  output logic         ioctl_wait,
  input  logic         vblank,
  output logic [127:0] palette,
  output logic         commit_stb,
  output logic         load_error
);

  pal_state_t             state, state_nx;
  logic [127:0]           shadow;
  logic [PAL_BYTES-1:0]   mask;
  logic                   overflow;

  logic dl_fall, dl_rise_unused;
  logic start, file_ok, addr_in_range;
  logic [3:0] byte_idx;

  edge_det u_dl_edge (
    .clk  (clk_sys),
    .rst  (reset),
    .d    (ioctl_download),
    .rise (dl_rise_unused),
    .fall (dl_fall)
  );

`ifdef PCW_PAL_VBLANK_SYNC_EN
  logic vbl_rise, vbl_fall_unused;

  edge_det u_vbl_edge (
    .clk  (clk_sys),
    .rst  (reset),
    .d    (vblank),
    .rise (vbl_rise),
    .fall (vbl_fall_unused)
  );
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
`endif

  // Level-sensitive: a download that began while busy is picked up as soon
  // as we are back in IDLE.
  assign start         = ioctl_download && (ioctl_index == PAL_INDEX);
  assign file_ok       = (mask == {PAL_BYTES{1'b1}}) && !overflow;
  assign addr_in_range = (ioctl_addr[15:4] == 12'd0);
  assign byte_idx      = ioctl_addr[3:0];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= PAL_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      PAL_IDLE:  if (start) state_nx = PAL_RECV;
      PAL_RECV:  if (dl_fall) state_nx = PAL_CHECK;
      PAL_CHECK: begin
        if (file_ok) begin
`ifdef PCW_PAL_VBLANK_SYNC_EN
          state_nx = PAL_WAIT_VBL;
`else
          state_nx = PAL_COMMIT;
`endif
        end else begin
          state_nx = PAL_IDLE;
        end
      end
`ifdef PCW_PAL_VBLANK_SYNC_EN
      PAL_WAIT_VBL: if (vbl_rise) state_nx = PAL_COMMIT;
`endif
      PAL_COMMIT: state_nx = PAL_IDLE;
      default:    state_nx = PAL_IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = (state == PAL_CHECK) || (state == PAL_COMMIT);
`ifdef PCW_PAL_VBLANK_SYNC_EN
    if (state == PAL_WAIT_VBL) ioctl_wait = 1'b1;
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      palette    <= DEFAULT_PALETTE;
      shadow     <= DEFAULT_PALETTE;
      mask       <= '0;
      overflow   <= 1'b0;
      commit_stb <= 1'b0;
      load_error <= 1'b0;
    end else begin
      commit_stb <= 1'b0;
      case (state)
        PAL_IDLE: begin
          // Seed the shadow with the live palette so an untouched byte keeps
          // its current value (only matters for diagnostics; a commit needs
          // every byte written anyway).
          if (start) begin
            shadow     <= palette;
            mask       <= '0;
            overflow   <= 1'b0;
            load_error <= 1'b0;
          end
        end
        PAL_RECV: begin
          // Also captures a strobe coincident with the download falling edge.
          if (ioctl_wr) begin
            if (addr_in_range) begin
              // Big-endian: byte a lands at bits 127-8a; ~a == 15-a for 4 bits.
              shadow[{~byte_idx, 3'b000} +: 8] <= ioctl_data;
              mask[byte_idx]                    <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        PAL_CHECK: begin
          if (!file_ok) load_error <= 1'b1;
        end
        PAL_COMMIT: begin
          palette    <= shadow;
          commit_stb <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcw_palette_loader.sv
// Directed bench for pcw_palette_loader. Inputs change on the falling clock
// edge, outputs are sampled on the falling edge as well.
module tb_pcw_palette_loader;

  localparam logic [127:0] DEF = 128'h00000032cd320000ff00ffff00000000;
  localparam logic [127:0] P1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] P2  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] P3  = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] P4  = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic         ioctl_download;
  logic [7:0]   ioctl_index;
  logic         ioctl_wr;
  logic [15:0]  ioctl_addr;
  logic [7:0]   ioctl_data;
  logic         ioctl_wait;
  logic         vblank;
  logic [127:0] palette;
  logic         commit_stb;
  logic         load_error;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic wait_seen = 1'b0;
  logic [127:0] cur;

  pcw_palette_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .vblank         (vblank),
    .palette        (palette),
    .commit_stb     (commit_stb),
    .load_error     (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (commit_stb === 1'b1) pulses++;
    if (ioctl_wait === 1'b1) wait_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic put(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
  endtask

  // Last byte strobed in the same cycle the download drops.
  task automatic put_last(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr       = 1'b1;
    ioctl_addr     = a;
    ioctl_data     = d;
    ioctl_download = 1'b0;
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
  endtask

  task automatic expect_commit(input string tag, input logic [127:0] exp, input logic [127:0] old);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk({tag, "_check_wait"}, 128'(ioctl_wait), 128'(1'b1));
    chk({tag, "_check_pal"}, palette, old);
`ifdef PCW_PAL_VBLANK_SYNC_EN
    @(negedge clk_sys);
    chk({tag, "_vbl_wait"}, 128'(ioctl_wait), 128'(1'b1));
    vblank = 1'b1;
    @(negedge clk_sys);
    vblank = 1'b0;
`else
    @(negedge clk_sys);
`endif
    chk({tag, "_commit_wait"}, 128'(ioctl_wait), 128'(1'b1));
    chk({tag, "_commit_pal_old"}, palette, old);
    @(negedge clk_sys);
    chk({tag, "_pal_new"}, palette, exp);
    chk({tag, "_stb"}, 128'(commit_stb), 128'(1'b1));
    chk({tag, "_wait_low"}, 128'(ioctl_wait), 128'(1'b0));
    @(negedge clk_sys);
    chk({tag, "_stb_low"}, 128'(commit_stb), 128'(1'b0));
  endtask

  task automatic expect_reject(input string tag, input logic [127:0] old);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk({tag, "_check_wait"}, 128'(ioctl_wait), 128'(1'b1));
    @(negedge clk_sys);
    chk({tag, "_idle_wait"}, 128'(ioctl_wait), 128'(1'b0));
    chk({tag, "_err"}, 128'(load_error), 128'(1'b1));
    chk({tag, "_pal"}, palette, old);
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 16'd0;
    ioctl_data     = 8'd0;
    vblank         = 1'b0;

    // Reset state
    #12;
    chk("rst_pal", palette, DEF);
    chk("rst_stb", 128'(commit_stb), 128'(1'b0));
    chk("rst_err", 128'(load_error), 128'(1'b0));
    chk("rst_wait", 128'(ioctl_wait), 128'(1'b0));
    @(negedge clk_sys);
    reset = 1'b0;

    // Valid file 00..0F
    start_dl(8'd3);
    for (int i = 0; i < 16; i++) put(16'(i), 8'(i));
    end_dl();
    expect_commit("valid1", P1, DEF);
    chk("valid1_pulses", 128'(pulses), 128'(1));
    chk("valid1_err", 128'(load_error), 128'(1'b0));

    // Truncated file: 15 bytes
    start_dl(8'd3);
    for (int i = 0; i < 15; i++) put(16'(i), 8'hAA);
    end_dl();
    expect_reject("short", P1);
    chk("short_pulses", 128'(pulses), 128'(1));

    // Oversized file: byte at addr 16
    start_dl(8'd3);
    for (int i = 0; i < 16; i++) put(16'(i), 8'(8'h10 + i));
    put(16'd16, 8'hFF);
    end_dl();
    expect_reject("over", P1);
    chk("over_pulses", 128'(pulses), 128'(1));

    // Valid file after rejection: error clears on entry, rewrite of addr 0,
    // last byte coincident with the download falling edge
    start_dl(8'd3);
    @(negedge clk_sys);
    chk("valid2_err_clr", 128'(load_error), 128'(1'b0));
    put(16'd0, 8'h99);
    for (int i = 0; i < 15; i++) put(16'(i), 8'(8'hA0 + i));
    put_last(16'd15, 8'hAF);
    expect_commit("valid2", P2, P1);
    chk("valid2_pulses", 128'(pulses), 128'(2));
    chk("valid2_err", 128'(load_error), 128'(1'b0));
    cur = P2;

    // Non-matching index: ignored entirely
    wait_seen = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 16; i++) put(16'(i), 8'h55);
    end_dl();
    repeat (4) @(negedge clk_sys);
    chk("idx0_wait_seen", 128'(wait_seen), 128'(1'b0));
    chk("idx0_pal", palette, P2);
    chk("idx0_pulses", 128'(pulses), 128'(2));
    chk("idx0_err", 128'(load_error), 128'(1'b0));

`ifdef PCW_PAL_VBLANK_SYNC_EN
    // vblank already high at CHECK must not commit; wait for the next rise
    start_dl(8'd3);
    vblank = 1'b1;
    for (int i = 0; i < 16; i++) put(16'(i), 8'(8'hC0 + i));
    end_dl();
    @(negedge clk_sys);
    chk("vbl_check_wait", 128'(ioctl_wait), 128'(1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      chk("vbl_hold_wait", 128'(ioctl_wait), 128'(1'b1));
      chk("vbl_hold_pal", palette, P2);
    end
    vblank = 1'b0;
    @(negedge clk_sys);
    vblank = 1'b1;
    @(negedge clk_sys);
    chk("vbl_commit_wait", 128'(ioctl_wait), 128'(1'b1));
    chk("vbl_commit_pal_old", palette, P2);
    @(negedge clk_sys);
    chk("vbl_pal_new", palette, P3);
    chk("vbl_stb", 128'(commit_stb), 128'(1'b1));
    vblank = 1'b0;
    @(negedge clk_sys);
    chk("vbl_pulses", 128'(pulses), 128'(3));
    cur = P3;
`endif

    // Reset mid-download after 8 bytes
    start_dl(8'd3);
    for (int i = 0; i < 8; i++) put(16'(i), 8'h77);
    @(negedge clk_sys);
    reset          = 1'b1;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("midrst_pal", palette, DEF);
    chk("midrst_wait", 128'(ioctl_wait), 128'(1'b0));
    chk("midrst_err", 128'(load_error), 128'(1'b0));
    chk("midrst_stb", 128'(commit_stb), 128'(1'b0));
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("midrst_pal_hold", palette, DEF);
    chk("midrst_wait_hold", 128'(ioctl_wait), 128'(1'b0));

    // Full download after reset commits normally
    start_dl(8'd3);
    for (int i = 0; i < 16; i++) put(16'(i), 8'(8'h11 * i));
    end_dl();
    expect_commit("post_rst", P4, DEF);
    chk("post_rst_err", 128'(load_error), 128'(1'b0));
    chk("post_rst_cur_changed", 128'(palette != cur), 128'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
